// File: rtl/frodo_inst_pkg.sv
// Shared definitions for the instruction queue.
// Holds the instruction-word field offsets, field widths, the NOP opcode
// and the small field typedefs used by inst_queue and its bench.
package frodo_inst_pkg;

  localparam int OPC_W    = 3;
  localparam int LVL_W    = 2;

  // Field LSB positions inside the instruction word
  localparam int OPC_LSB  = 24;
  localparam int A_LSB    = 20;
  localparam int B_LSB    = 16;
  localparam int C_LSB    = 12;
  localparam int MODE_BIT = 11;

  typedef logic [OPC_W-1:0] opcode_t;
  typedef logic [LVL_W-1:0] level_t;

  localparam opcode_t OPC_NOP = 3'b000;

  // Width of one stored queue entry for a given operand index width
  function automatic int entry_width(input int idx_w);
    return OPC_W + 3 * idx_w + 1 + LVL_W;
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// Circular-buffer storage for the instruction queue.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   flush_i   - empty the buffer next cycle (stored words are abandoned)
//   push_i    - write data_i at the tail (caller guarantees not full)
//   data_i    - entry to write
//   pop_i     - advance the head (caller guarantees not empty)
//   head_o    - entry at the head, read combinationally
//   count_o   - number of valid entries, 0..DEPTH
module inst_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked purely by count_q.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/inst_queue.sv
// In-order instruction queue with an operand scoreboard.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   inst, inst_valid, level  - incoming instruction word and security tag
//   inst_ready               - queue has room (no pass-through when full)
//   flush                    - drop every queued, unissued instruction
//   issue_*                  - head instruction offered to the unit
//   done, done_idx           - unit finished writing operand done_idx
//   count                    - queued entries
//   busy_map                 - one pending-write bit per operand index
//   ovf                      - sticky: a word arrived while full
module inst_queue
  import frodo_inst_pkg::*;
#(
  parameter int INST_WIDTH = 27,
  parameter int IDX_WIDTH  = 4,
  parameter int DEPTH      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [INST_WIDTH-1:0]     inst,
  input  logic                      inst_valid,
  input  logic [LVL_W-1:0]          level,
  output logic                      inst_ready,
  input  logic                      flush,
  output logic                      issue_valid,
  input  logic                      issue_ready,
  output logic [OPC_W-1:0]          issue_opcode,
  output logic [IDX_WIDTH-1:0]      issue_a,
  output logic [IDX_WIDTH-1:0]      issue_b,
  output logic [IDX_WIDTH-1:0]      issue_c,
  output logic                      issue_mode,
  output logic [LVL_W-1:0]          issue_level,
  input  logic                      done,
  input  logic [IDX_WIDTH-1:0]      done_idx,
  output logic [$clog2(DEPTH):0]    count,
  output logic [2**IDX_WIDTH-1:0]   busy_map,
  output logic                      ovf
);

  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int EW   = entry_width(IDX_WIDTH);
  localparam int NREG = 2**IDX_WIDTH;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [EW-1:0]        push_data, head_data;
  logic [CW-1:0]        fifo_count;
  logic                 push, pop, fire, nop_pop, non_empty, hazard_free;

  opcode_t              h_opc;
  logic [IDX_WIDTH-1:0] h_a, h_b, h_c;
  logic                 h_mode;
  level_t               h_lvl;

  logic [NREG-1:0]      busy_q, busy_d;
  logic                 ovf_q, ovf_d;

  // Reserved bits are carried on the port but never stored.
  logic unused_inst;
  assign unused_inst = ^inst;

  assign push_data = {inst[OPC_LSB +: OPC_W],
                      inst[A_LSB +: IDX_WIDTH],
                      inst[B_LSB +: IDX_WIDTH],
                      inst[C_LSB +: IDX_WIDTH],
                      inst[MODE_BIT],
                      level};

  assign {h_opc, h_a, h_b, h_c, h_mode, h_lvl} = head_data;

  assign non_empty   = (fifo_count != '0);
  assign inst_ready  = (fifo_count != FULL_CNT);
  // Scoreboard is read registered: a result finishing this cycle only
  // unblocks the head on the following cycle.
  assign hazard_free = !(busy_q[h_a] || busy_q[h_b] || busy_q[h_c]);

  // flush and rst suppress the handshake so nothing issues as the queue
  // is being emptied.
  assign issue_valid = non_empty && (h_opc != OPC_NOP) && hazard_free
                       && !flush && !rst;
  assign fire        = issue_valid && issue_ready;
  assign nop_pop     = non_empty && (h_opc == OPC_NOP) && !flush && !rst;
  assign pop         = fire || nop_pop;
  // Readiness is judged on the pre-pop count: a full queue never accepts.
  assign push        = inst_valid && inst_ready && !flush;

  inst_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .head_o  (head_data),
    .count_o (fifo_count)
  );

  // Set is applied after clear so an issue to the same index wins.
  always_comb begin
    busy_d = busy_q;
    if (done) busy_d[done_idx] = 1'b0;
    if (fire) busy_d[h_c]      = 1'b1;
  end

  assign ovf_d = ovf_q || (inst_valid && !inst_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      ovf_q  <= ovf_d;
    end
  end

  assign issue_opcode = h_opc;
  assign issue_a      = h_a;
  assign issue_b      = h_b;
  assign issue_c      = h_c;
  assign issue_mode   = h_mode;
  assign issue_level  = h_lvl;
  assign count        = fifo_count;
  assign busy_map     = busy_q;
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: a queue-level reference model checked
// against the DUT every cycle, plus literal checks at key points.
module tb_inst_queue;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [26:0] inst = '0;
  logic        inst_valid = 1'b0;
  logic [1:0]  level = '0;
  logic        inst_ready;
  logic        flush = 1'b0;
  logic        issue_valid;
  logic        issue_ready = 1'b0;
  logic [2:0]  issue_opcode;
  logic [3:0]  issue_a, issue_b, issue_c;
  logic        issue_mode;
  logic [1:0]  issue_level;
  logic        done = 1'b0;
  logic [3:0]  done_idx = '0;
  logic [3:0]  count;
  logic [15:0] busy_map;
  logic        ovf;

  inst_queue #(.INST_WIDTH(27), .IDX_WIDTH(4), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid),
    .level(level), .inst_ready(inst_ready), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_opcode(issue_opcode), .issue_a(issue_a), .issue_b(issue_b),
    .issue_c(issue_c), .issue_mode(issue_mode), .issue_level(issue_level),
    .done(done), .done_idx(done_idx), .count(count),
    .busy_map(busy_map), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [2:0] op;
    logic [3:0] a, b, c;
    logic       mode;
    logic [1:0] lvl;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] m_busy = '0;
  logic        m_ovf  = 1'b0;

  function automatic ent_t decode(input logic [26:0] w, input logic [1:0] l);
    ent_t e;
    e.op = w[26:24]; e.a = w[23:20]; e.b = w[19:16]; e.c = w[15:12];
    e.mode = w[11];  e.lvl = l;
    return e;
  endfunction

  function automatic bit m_valid();
    if (mq.size() == 0) return 1'b0;
    if (flush || rst) return 1'b0;
    if (mq[0].op == 3'd0) return 1'b0;
    return !(m_busy[mq[0].a] || m_busy[mq[0].b] || m_busy[mq[0].c]);
  endfunction

  always @(posedge clk) begin
    bit         full, fire, pop;
    logic [3:0] fc;
    full = (mq.size() == DEPTH);
    fire = m_valid() && issue_ready;
    fc   = fire ? mq[0].c : 4'd0;
    if (rst) begin
      mq.delete();
      m_busy = '0;
      m_ovf  = 1'b0;
    end else begin
      if (inst_valid && full) m_ovf = 1'b1;
      if (flush) begin
        mq.delete();
      end else begin
        pop = fire || (mq.size() != 0 && mq[0].op == 3'd0);
        if (fire) $display("[TB] issue op=%0d a=%0d b=%0d c=%0d",
                           mq[0].op, mq[0].a, mq[0].b, mq[0].c);
        if (pop) void'(mq.pop_front());
        if (inst_valid && !full) begin
          mq.push_back(decode(inst, level));
          $display("[TB] enqueue op=%0d", inst[26:24]);
        end
      end
      if (done) m_busy[done_idx] = 1'b0;
      if (fire) m_busy[fc] = 1'b1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      bit ev;
      ev = m_valid();
      check("issue_valid", {31'd0, issue_valid}, {31'd0, ev});
      check("count", {28'd0, count}, mq.size());
      check("inst_ready", {31'd0, inst_ready}, {31'd0, mq.size() != DEPTH});
      check("busy_map", {16'd0, busy_map}, {16'd0, m_busy});
      check("ovf", {31'd0, ovf}, {31'd0, m_ovf});
      if (ev) begin
        check("issue_opcode", {29'd0, issue_opcode}, {29'd0, mq[0].op});
        check("issue_a", {28'd0, issue_a}, {28'd0, mq[0].a});
        check("issue_b", {28'd0, issue_b}, {28'd0, mq[0].b});
        check("issue_c", {28'd0, issue_c}, {28'd0, mq[0].c});
        check("issue_mode", {31'd0, issue_mode}, {31'd0, mq[0].mode});
        check("issue_level", {30'd0, issue_level}, {30'd0, mq[0].lvl});
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [26:0] mk(input int op, input int a, input int b,
                                     input int c, input int mode);
    logic [2:0] o; logic [3:0] ia, ib, ic; logic m;
    o = op[2:0]; ia = a[3:0]; ib = b[3:0]; ic = c[3:0]; m = mode[0];
    return {o, ia, ib, ic, m, 11'h5A5};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [26:0] w, input logic [1:0] l);
    inst = w; level = l; inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0;
  endtask

  task automatic retire(input int idx);
    done = 1'b1; done_idx = idx[3:0];
    tick();
    done = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_count", {28'd0, count}, 32'd0);
    check("rst_ready", {31'd0, inst_ready}, 32'd1);
    check("rst_valid", {31'd0, issue_valid}, 32'd0);
    check("rst_busy", {16'd0, busy_map}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);

    // Single issue then retire
    issue_ready = 1'b1;
    enq(mk(4, 1, 2, 3, 1), 2'd1);
    check("t1_valid", {31'd0, issue_valid}, 32'd1);
    check("t1_level", {30'd0, issue_level}, 32'd1);
    tick();
    check("t1_busy", {16'd0, busy_map}, 32'h0008);
    retire(3);
    check("t1_clear", {16'd0, busy_map}, 32'h0000);

    // RAW hazard on A blocks the second word
    enq(mk(4, 1, 2, 3, 0), 2'd0);
    enq(mk(5, 3, 4, 5, 0), 2'd3);
    check("t2_stall", {31'd0, issue_valid}, 32'd0);
    repeat (2) tick();
    check("t2_still", {31'd0, issue_valid}, 32'd0);
    retire(3);
    check("t2_go", {31'd0, issue_valid}, 32'd1);
    check("t2_op", {29'd0, issue_opcode}, 32'd5);
    tick();
    check("t2_busy", {16'd0, busy_map}, 32'h0020);
    retire(5);

    // Fill past capacity, then drain through pointer wrap
    issue_ready = 1'b0;
    for (int k = 0; k < 9; k++) enq(mk(1, k, k, k + 8, k), k[1:0]);
    check("t3_count", {28'd0, count}, 32'd8);
    check("t3_ready", {31'd0, inst_ready}, 32'd0);
    check("t3_ovf", {31'd0, ovf}, 32'd1);
    issue_ready = 1'b1;
    repeat (10) tick();
    check("t3_drained", {28'd0, count}, 32'd0);
    check("t3_busy", {16'd0, busy_map}, 32'hFF00);
    for (int k = 8; k < 16; k++) retire(k);
    check("t3_clear", {16'd0, busy_map}, 32'h0000);

    // NOP is consumed silently
    enq(mk(0, 0, 0, 0, 0), 2'd0);
    check("t4_nop", {31'd0, issue_valid}, 32'd0);
    enq(mk(6, 0, 0, 2, 0), 2'd0);
    check("t4_op", {29'd0, issue_opcode}, 32'd6);
    check("t4_valid", {31'd0, issue_valid}, 32'd1);
    tick();
    check("t4_busy", {16'd0, busy_map}, 32'h0004);

    // Flush keeps the scoreboard and ignores a same-cycle enqueue
    issue_ready = 1'b0;
    for (int k = 0; k < 5; k++) enq(mk(2, 1, 1, 1, 0), 2'd0);
    check("t5_count", {28'd0, count}, 32'd5);
    flush = 1'b1; inst = mk(3, 0, 0, 0, 0); inst_valid = 1'b1;
    tick();
    flush = 1'b0; inst_valid = 1'b0;
    check("t5_empty", {28'd0, count}, 32'd0);
    check("t5_valid", {31'd0, issue_valid}, 32'd0);
    check("t5_busy", {16'd0, busy_map}, 32'h0004);
    retire(2);

    // Same-cycle done and issue to index 3: set wins
    enq(mk(7, 1, 1, 3, 0), 2'd0);
    issue_ready = 1'b1; done = 1'b1; done_idx = 4'd3;
    tick();
    done = 1'b0;
    check("t6_busy", {16'd0, busy_map}, 32'h0008);

    // Reset in the middle of traffic
    enq(mk(5, 4, 4, 6, 0), 2'd0);
    enq(mk(5, 6, 6, 7, 0), 2'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t7_count", {28'd0, count}, 32'd0);
    check("t7_busy", {16'd0, busy_map}, 32'd0);
    check("t7_ovf", {31'd0, ovf}, 32'd0);
    check("t7_ready", {31'd0, inst_ready}, 32'd1);
    tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
